// File: rtl/lut_share_pkg.sv
// lut_share_pkg: shared state encoding and width helpers for the LUT sharing scheduler.
package lut_share_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, LOAD, SERVE} state_t;
   function automatic int dw_out(input int k, input int b);
      return b + $clog2(k) + 1;
   endfunction
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr.
module rr_arbiter import lut_share_pkg::*; #(
   parameter int N = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant
);
   logic [IW-1:0] j;
   // Walk from farthest to nearest so the requester closest to ptr wins.
   always_comb begin
      grant = '0;
      j = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % N);
         if (en && req[j]) begin
            grant = '0;
            grant[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/lut_share_sched.sv
// lut_share_sched: shares one DA LUT among N_REQ requesters and sequences table rebuilds.
module lut_share_sched import lut_share_pkg::*; #(
   parameter int K = 8,
   parameter int DATA_WIDTH_B = 16,
   parameter int N_REQ = 4,
   parameter int BUILD_CYCLES = 4,
   parameter int LUT_LAT = 1,
   localparam int DW = dw_out(K, DATA_WIDTH_B),
   localparam int IW = idx_w(N_REQ),
   localparam int CW = $clog2(BUILD_CYCLES + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wt_valid,
   output logic                         wt_ready,
   output logic                         lut_gen_done,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0][K-2:0]      req_addr,
   output logic [N_REQ-1:0]             req_ready,
   output logic [K-2:0]                 lut_addr,
   input  logic signed [DW-1:0]         lut_data,
   output logic                         resp_valid,
   output logic [IW-1:0]                resp_id,
   output logic signed [DW-1:0]         resp_data,
   output logic                         table_valid
);
   state_t state;
   logic [IW-1:0] ptr, gidx;
   logic [CW-1:0] cnt;
   logic [K-2:0] addr_q;
   logic [LUT_LAT-1:0] pv;
   logic [LUT_LAT-1:0][IW-1:0] pid;
   logic gnt, en, empty;
   assign en = !rst && state == SERVE && !wt_valid;
   assign empty = ~|pv;
   assign wt_ready = !rst && (state == IDLE || (state == DRAIN && empty && wt_valid));
   assign lut_gen_done = wt_valid && wt_ready;
   rr_arbiter #(.N(N_REQ)) u_arb (
      .req(req_valid),
      .ptr(ptr),
      .en(en),
      .grant(req_ready)
   );
   assign gnt = |req_ready;
   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gidx = IW'(i);
   end
   assign lut_addr = gnt ? req_addr[gidx] : addr_q;
   assign resp_valid = pv[LUT_LAT-1];
   assign resp_id = resp_valid ? pid[LUT_LAT-1] : '0;
   assign resp_data = resp_valid ? lut_data : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         addr_q <= '0;
         pv <= '0;
         pid <= '0;
         table_valid <= 1'b0;
      end else begin
         for (int i = LUT_LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pid[i] <= pid[i-1];
         end
         pv[0] <= gnt;
         pid[0] <= gidx;
         if (gnt) begin
            addr_q <= lut_addr;
            ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
         end
         unique case (state)
            IDLE: if (wt_valid) state <= LOAD;
            LOAD: begin
               cnt <= (cnt == CW'(BUILD_CYCLES - 1)) ? '0 : cnt + 1'b1;
               if (cnt == CW'(BUILD_CYCLES - 1)) begin
                  state <= SERVE;
                  table_valid <= 1'b1;
               end
            end
            SERVE: if (wt_valid) state <= DRAIN;
            DRAIN: begin
               // In-flight lookups must finish against the old table before the rebuild starts.
               if (!wt_valid) state <= SERVE;
               else if (empty) begin
                  state <= LOAD;
                  table_valid <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/lut_share_sched.md
LUT_SHARE_SCHED -- requirements
Module: lut_share_sched

Interface
REQ-001 Parameter K, default 8, sets the DA input count; the LUT address is K-1 bits.
REQ-002 Parameter DATA_WIDTH_B, default 16, sets the weight width; DW_OUT = DATA_WIDTH_B+$clog2(K)+1, which is 20 at the defaults.
REQ-003 Parameter N_REQ, default 4, sets the number of lookup requesters (2..8).
REQ-004 Parameter BUILD_CYCLES, default 4, sets the number of cycles the LUT needs after gen_done to rebuild its table (at least 1).
REQ-005 Parameter LUT_LAT, default 1, sets the cycles from lut_addr to valid lut_data (at least 1).
REQ-006 clk  in  1  the single clock; all logic is on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wt_valid  in  1  the weight source holds a new B_temp set stable.
REQ-009 wt_ready  out  1  the scheduler accepts the weight set this cycle.
REQ-010 lut_gen_done  out  1  one-cycle pulse telling the LUT to build from B_temp.
REQ-011 req_valid  in  N_REQ  per-requester lookup request.
REQ-012 req_addr  in  N_REQ x (K-1)  per-requester LUT address.
REQ-013 req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
REQ-014 lut_addr  out  K-1  address driven to the shared LUT.
REQ-015 lut_data  in  DW_OUT signed  LUT_out from the shared LUT.
REQ-016 resp_valid  out  1  the response is valid.
REQ-017 resp_id  out  $clog2(N_REQ)  index of the requester that owns the response.
REQ-018 resp_data  out  DW_OUT signed  the looked-up value.
REQ-019 table_valid  out  1  the LUT holds a completed table.

Function
REQ-020 The FSM states SHALL be IDLE, DRAIN, LOAD and SERVE.
REQ-021 IDLE: wt_ready=1 and no grants are issued; wt_valid moves the FSM to LOAD and pulses lut_gen_done on that same cycle.
REQ-022 LOAD: a counter SHALL run for BUILD_CYCLES cycles, then the FSM moves to SERVE and table_valid is set to 1; no grants are issued in LOAD.
REQ-023 SERVE: each cycle, one requester with req_valid=1 SHALL be granted in round-robin order, starting the search from ptr.
REQ-024 After a grant to requester i, ptr SHALL become (i+1) mod N_REQ; ptr is unchanged when nothing is granted.
REQ-025 On a grant, lut_addr SHALL equal the granted req_addr in that same cycle (combinational mux); otherwise lut_addr holds its last value.
REQ-026 A tag pipeline of depth LUT_LAT (valid, id) SHALL make resp_valid=1 exactly LUT_LAT cycles after the grant cycle, with resp_data=lut_data and resp_id set to the granted index.
REQ-027 Full throughput: one lookup is accepted per cycle in SERVE, with no bubbles between back-to-back grants.
REQ-028 wt_valid in SERVE SHALL take priority over new grants: req_ready is forced to 0 and the FSM enters DRAIN.
REQ-029 DRAIN: the FSM waits until the tag pipeline is empty, then asserts wt_ready for one cycle, pulses lut_gen_done, clears table_valid and enters LOAD.
REQ-030 Lookups already in flight when DRAIN is entered SHALL complete with data from the old table.
REQ-031 If wt_valid is deasserted while in DRAIN, the FSM returns to SERVE with table_valid still 1.
REQ-032 wt_valid during LOAD SHALL be ignored; wt_ready=0 in LOAD.
REQ-033 When a grant and the wt_valid detection happen in the same SERVE cycle, the grant is suppressed (per REQ-028).
REQ-034 A requester that deasserts req_valid before being granted loses its turn; no response is issued for it.
REQ-035 Requests with req_valid=0 SHALL never be granted, and at most one bit of req_ready is high in any cycle.

Reset
REQ-036 rst SHALL force the state to IDLE, ptr to 0, the LOAD counter to 0 and the tag pipeline to empty.
REQ-037 Reset values of outputs: wt_ready=0 in the reset cycle, lut_gen_done=0, req_ready=0, lut_addr=0, resp_valid=0, resp_id=0, resp_data=0, table_valid=0.
REQ-038 Reset mid-operation SHALL discard all in-flight responses; no resp_valid appears after reset until new grants are issued.

Structure
REQ-039 The shared package lut_share_pkg SHALL hold the state enum, the DW_OUT width function and the requester-index width function.
REQ-040 Round-robin selection SHALL be a sub-module, rr_arbiter (inputs: request vector, ptr, enable; output: one-hot grant); the FSM, LOAD counter and tag pipeline stay in lut_share_sched.

Verification
REQ-041 Reset, then wt_valid=1 for 1 cycle -> lut_gen_done pulses on cycle 0; table_valid=1 after 4 cycles; before that, req_ready stays 0.
REQ-042 SERVE with req_valid=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each resp_valid comes 1 cycle later with the matching resp_id.
REQ-043 Requester 2 alone with req_addr=7'h55 and the LUT model returning 20'sh0F0F0 -> resp_id=2, resp_data=20'sh0F0F0 one cycle after the grant.
REQ-044 wt_valid rises during continuous requests with LUT_LAT=3 -> req_ready drops at once; 3 old-table responses complete; then lut_gen_done pulses, table_valid=0 for 4 cycles and grants resume.
REQ-045 rst asserted with 2 lookups in flight -> resp_valid stays 0 afterwards; ptr=0 and the state returns to IDLE.
REQ-046 req_valid=4'b1010 with ptr=2 -> the grant goes to 3, then 1, then 3 again; requesters 0 and 2 are never granted.
